// File: rtl/rv32i_control_unit_if.sv
// rv32i_control_unit_if: instruction fields in, registered datapath controls out
interface rv32i_control_unit_if;
  logic [6:0] opcode;
  logic [6:0] funct_7;
  logic [2:0] funct_3;
  logic       regwrite;
  logic       memread;
  logic       memwrite;
  logic       memtoreg;
  logic       alusrc;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic [2:0] imm_type;
  logic [3:0] alucontrol;
  modport master (
    output opcode, funct_7, funct_3,
    input  regwrite, memread, memwrite, memtoreg, alusrc, pc_write, pc_sel, imm_type, alucontrol
  );
  modport slave (
    input  opcode, funct_7, funct_3,
    output regwrite, memread, memwrite, memtoreg, alusrc, pc_write, pc_sel, imm_type, alucontrol
  );
endinterface

// File: rtl/rv32i_control_unit.sv
// rv32i_control_unit: registered RV32I main decoder; illegal encodings become a PC-freezing NOP
module rv32i_control_unit (
  input logic clk,
  input logic rst_n,
  rv32i_control_unit_if.slave bus
);
  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic [2:0] imm_type;
    logic [3:0] alucontrol;
  } ctrl_t;
  ctrl_t      d;
  logic       legal;
  logic       alt;
  logic [3:0] alu_op;
  logic [2:0] f3;
  assign f3 = bus.funct_3;
  // alt picks SUB/SRA; I-type ADDI never subtracts, shifts use funct_7[5]
  assign alt = bus.opcode == 7'b0110011 ? bus.funct_7[5] : (f3 == 3'b101 && bus.funct_7[5]);
  assign alu_op = f3 == 3'b000 ? {3'b000, alt} :
                  f3 == 3'b101 ? {3'b011, alt} :
                  f3[2:1] == 2'b11 ? {3'b100, f3[0]} : {1'b0, f3} + 4'd1;
  always_comb begin
    d = '0;
    legal = 1'b1;
    d.pc_write = 1'b1;
    case (bus.opcode)
      7'b0110011: begin
        d.regwrite = 1'b1;
        d.alucontrol = alu_op;
        legal = bus.funct_7 == 7'b0000000 || (bus.funct_7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0010011: begin
        d.regwrite = 1'b1;
        d.alusrc = 1'b1;
        d.imm_type = 3'd1;
        d.alucontrol = alu_op;
      end
      7'b0000011: begin
        d.regwrite = 1'b1;
        d.memread = 1'b1;
        d.memtoreg = 1'b1;
        d.alusrc = 1'b1;
        d.imm_type = 3'd1;
      end
      7'b0100011: begin
        d.memwrite = 1'b1;
        d.alusrc = 1'b1;
        d.imm_type = 3'd2;
      end
      7'b1100011: begin
        d.imm_type = 3'd3;
        d.pc_sel = 2'd1;
        d.alucontrol = f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd1;
        legal = f3[2:1] != 2'b01;
      end
      7'b1101111: begin
        d.regwrite = 1'b1;
        d.imm_type = 3'd5;
        d.pc_sel = 2'd2;
      end
      7'b1100111: begin
        d.regwrite = 1'b1;
        d.alusrc = 1'b1;
        d.imm_type = 3'd1;
        d.pc_sel = 2'd3;
        legal = f3 == 3'b000;
      end
      7'b0110111: begin
        d.regwrite = 1'b1;
        d.alusrc = 1'b1;
        d.imm_type = 3'd4;
        d.alucontrol = 4'd10;
      end
      7'b0010111: begin
        d.regwrite = 1'b1;
        d.alusrc = 1'b1;
        d.imm_type = 3'd4;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) d = '0;
  end
  always_ff @(posedge clk)
    {bus.regwrite, bus.memread, bus.memwrite, bus.memtoreg, bus.alusrc, bus.pc_write,
     bus.pc_sel, bus.imm_type, bus.alucontrol} <= rst_n ? d : '0;
endmodule

// File: tb/tb_rv32i_control_unit.sv
// tb_rv32i_control_unit: directed decode vectors with hand-computed control words
module tb_rv32i_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  rv32i_control_unit_if bus ();
  rv32i_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] e(input logic rw, mr, mw, mt, as, pw,
                                    input logic [1:0] ps, input logic [2:0] it, input logic [3:0] ac);
    return {rw, mr, mw, mt, as, pw, ps, it, ac};
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] obs();
    return {bus.regwrite, bus.memread, bus.memwrite, bus.memtoreg, bus.alusrc, bus.pc_write,
            bus.pc_sel, bus.imm_type, bus.alucontrol};
  endfunction
  task automatic apply(input string tag, input logic [6:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [15:0] exp);
    bus.opcode = op;
    bus.funct_7 = f7;
    bus.funct_3 = f3;
    @(posedge clk);
    #1 check(tag, obs(), exp);
  endtask
  task automatic apply_instr(input string tag, input logic [31:0] i, input logic [15:0] exp);
    apply(tag, i[6:0], i[31:25], i[14:12], exp);
  endtask
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011;
  initial begin
    bus.opcode = 7'h13;
    bus.funct_7 = '0;
    bus.funct_3 = '0;
    rst_n = 1'b0;
    apply_instr("reset1", 32'h00A00613, '0);
    apply_instr("reset2", 32'h00A00613, '0);
    rst_n = 1'b1;
    apply_instr("addi", 32'h00A00613, e(1,0,0,0,1,1,0,1,0));
    apply_instr("beq", 32'h00060C63, e(0,0,0,0,0,1,1,3,1));
    apply_instr("jal", 32'hFEDFF06F, e(1,0,0,0,0,1,2,5,0));
    apply("bne", 7'b1100011, 7'h00, 3'b001, e(0,0,0,0,0,1,1,3,1));
    apply("blt", 7'b1100011, 7'h00, 3'b100, e(0,0,0,0,0,1,1,3,3));
    apply("bgeu", 7'b1100011, 7'h00, 3'b111, e(0,0,0,0,0,1,1,3,4));
    apply("br_ill", 7'b1100011, 7'h00, 3'b010, '0);
    apply("jalr", 7'b1100111, 7'h00, 3'b000, e(1,0,0,0,1,1,3,1,0));
    apply("jalr_ill", 7'b1100111, 7'h00, 3'b001, '0);
    apply("lui", 7'b0110111, 7'h12, 3'b101, e(1,0,0,0,1,1,0,4,10));
    apply("auipc", 7'b0010111, 7'h40, 3'b011, e(1,0,0,0,1,1,0,4,0));
    apply("lw", 7'b0000011, 7'h00, 3'b010, e(1,1,0,1,1,1,0,1,0));
    apply("sw", 7'b0100011, 7'h00, 3'b010, e(0,0,1,0,1,1,0,2,0));
    apply("add", R, 7'h00, 3'b000, e(1,0,0,0,0,1,0,0,0));
    apply("sub", R, 7'h20, 3'b000, e(1,0,0,0,0,1,0,0,1));
    apply("sll", R, 7'h00, 3'b001, e(1,0,0,0,0,1,0,0,2));
    apply("slt", R, 7'h00, 3'b010, e(1,0,0,0,0,1,0,0,3));
    apply("sltu", R, 7'h00, 3'b011, e(1,0,0,0,0,1,0,0,4));
    apply("xor", R, 7'h00, 3'b100, e(1,0,0,0,0,1,0,0,5));
    apply("srl", R, 7'h00, 3'b101, e(1,0,0,0,0,1,0,0,6));
    apply("sra", R, 7'h20, 3'b101, e(1,0,0,0,0,1,0,0,7));
    apply("or", R, 7'h00, 3'b110, e(1,0,0,0,0,1,0,0,8));
    apply("and", R, 7'h00, 3'b111, e(1,0,0,0,0,1,0,0,9));
    apply("mul_ill", R, 7'h01, 3'b000, '0);
    apply("r20_ill", R, 7'h20, 3'b001, '0);
    apply("addi_f7", I, 7'h20, 3'b000, e(1,0,0,0,1,1,0,1,0));
    apply("srai", I, 7'h20, 3'b101, e(1,0,0,0,1,1,0,1,7));
    apply("srli", I, 7'h00, 3'b101, e(1,0,0,0,1,1,0,1,6));
    apply("ori", I, 7'h00, 3'b110, e(1,0,0,0,1,1,0,1,8));
    apply("sltiu", I, 7'h00, 3'b011, e(1,0,0,0,1,1,0,1,4));
    apply("op0", 7'b0000000, 7'h00, 3'b000, '0);
    rst_n = 1'b0;
    apply("mid_reset", 7'b0110111, 7'h00, 3'b000, '0);
    rst_n = 1'b1;
    apply("post_reset", 7'b0110111, 7'h00, 3'b000, e(1,0,0,0,1,1,0,4,10));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
